systolic_seq_ctrl: RTL

//  Sequencer for the 4x4 systolic-array datapath: loads host words into the input SRAM, runs the array,

---
 rtl/systolic_seq_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: load/run/capture/drain sequencer for the 4x4 systolic array.
// Optional run watchdog enabled by defining SEQ_TIMEOUT_EN.
module systolic_seq_ctrl #(
  parameter int DEPTH       = 8,
  parameter int ADDR_W      = 3,
  parameter int OUT_W       = 64,
  parameter int RUN_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              load_valid,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              start,
  output logic              in_cs,
  output logic              in_wr,
  output logic [ADDR_W-1:0] in_addr,
  output logic              arr_input_en,
  input  logic              arr_output_en,
  output logic              out_cs,
  output logic              out_wr,
  output logic [ADDR_W-1:0] out_addr,
  input  logic [OUT_W-1:0]  out_dout,
  output logic [OUT_W-1:0]  res_data,
  output logic              res_valid,
  output logic              res_last,
  input  logic              res_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, LOAD, READY, RUN, DRAIN} state_t;
  localparam logic [ADDR_W:0] DEP = (ADDR_W+1)'(DEPTH);
  state_t state_q, state_d;
  logic [ADDR_W:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d, ccnt_q, ccnt_d, dcnt_q, dcnt_d;
  logic arr_en_q, arr_en_d, res_valid_q, res_valid_d, err_q, err_d;
  logic lr_c, in_cs_c, in_wr_c, out_cs_c, out_wr_c, done_c, tmo;
  logic [ADDR_W-1:0] in_addr_c, out_addr_c;
`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(RUN_TIMEOUT + 1);
  logic [TW-1:0] tcnt_q;
  always_ff @(posedge clk)
    tcnt_q <= (!rst_b || state_q != RUN) ? '0 : tcnt_q + 1'b1;
  assign tmo = tcnt_q == TW'(RUN_TIMEOUT - 1);
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    ccnt_d      = ccnt_q;
    dcnt_d      = dcnt_q;
    res_valid_d = res_valid_q;
    err_d       = err_q;
    arr_en_d    = 1'b0;
    lr_c        = 1'b0;
    in_cs_c     = 1'b0;
    in_wr_c     = 1'b0;
    in_addr_c   = '0;
    out_cs_c    = 1'b0;
    out_wr_c    = 1'b0;
    out_addr_c  = '0;
    done_c      = 1'b0;
    case (state_q)
      IDLE, LOAD: begin
        lr_c = wcnt_q < DEP;
        if (load_valid && lr_c) begin
          in_cs_c   = 1'b1;
          in_wr_c   = 1'b1;
          in_addr_c = wcnt_q[ADDR_W-1:0];
          wcnt_d    = wcnt_q + 1'b1;
          state_d   = (load_last || wcnt_d == DEP) ? READY : LOAD;
        end
      end
      READY: if (start) begin
        state_d = RUN;
        rcnt_d  = '0;
        ccnt_d  = '0;
      end
      RUN: begin
        // arr_input_en is the registered read strobe, lagging the SRAM read by one cycle
        if (rcnt_q < DEP) begin
          in_cs_c   = 1'b1;
          in_addr_c = rcnt_q[ADDR_W-1:0];
          rcnt_d    = rcnt_q + 1'b1;
          arr_en_d  = 1'b1;
        end
        if (arr_output_en && ccnt_q < DEP) begin
          out_cs_c   = 1'b1;
          out_wr_c   = 1'b1;
          out_addr_c = ccnt_q[ADDR_W-1:0];
          ccnt_d     = ccnt_q + 1'b1;
        end
        if (ccnt_d == DEP) state_d = DRAIN;
        else if (tmo) begin
          state_d  = IDLE;
          err_d    = 1'b1;
          arr_en_d = 1'b0;
          wcnt_d   = '0;
          rcnt_d   = '0;
          ccnt_d   = '0;
        end
      end
      DRAIN: begin
        if (res_valid_q && res_ready) res_valid_d = 1'b0;
        if (dcnt_q < DEP && (!res_valid_q || res_ready)) begin
          out_cs_c    = 1'b1;
          out_addr_c  = dcnt_q[ADDR_W-1:0];
          dcnt_d      = dcnt_q + 1'b1;
          res_valid_d = 1'b1;
        end
        if (res_valid_q && res_ready && dcnt_q == DEP) begin
          done_c  = 1'b1;
          state_d = IDLE;
          wcnt_d  = '0;
          rcnt_d  = '0;
          ccnt_d  = '0;
          dcnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      ccnt_q      <= '0;
      dcnt_q      <= '0;
      arr_en_q    <= 1'b0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      ccnt_q      <= ccnt_d;
      dcnt_q      <= dcnt_d;
      arr_en_q    <= arr_en_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
    end
  end
  // Every output is forced low while reset is held
  assign load_ready   = rst_b & lr_c;
  assign in_cs        = rst_b & in_cs_c;
  assign in_wr        = rst_b & in_wr_c;
  assign in_addr      = rst_b ? in_addr_c : '0;
  assign arr_input_en = rst_b & arr_en_q;
  assign out_cs       = rst_b & out_cs_c;
  assign out_wr       = rst_b & out_wr_c;
  assign out_addr     = rst_b ? out_addr_c : '0;
  assign res_data     = rst_b ? out_dout : '0;
  assign res_valid    = rst_b & res_valid_q;
  assign res_last     = res_valid & (dcnt_q == DEP);
  assign busy         = rst_b & (state_q != IDLE);
  assign done         = rst_b & done_c;
  assign err          = rst_b & err_q;
endmodule
